key_debounce: RTL and testbench
===============================

# key_debounce

Debounces and edge-detects the raw tank-control push-buttons (up, down, left, right, fire) using the slow square wave produced by the clock divider as its sample rate. It sits directly downstream of the divider. It consumes the divided clock as a data signal in the fast `I_CLK` domain, not as a clock. It feeds clean key levels and one-cycle press/release pulses to the tank control logic.

## Interface
- `N_KEYS`, default 5: number of independent key channels.
- `STABLE`, default 4: consecutive agreeing samples required to change a debounced state. Legal range is ≥1.
- `I_CLK`, input, 1: system clock. All logic is on its rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `I_TICK`, input, 1: divided clock from the divider. Asynchronous-safe square wave, period ≥ 8 `I_CLK` cycles.
- `I_KEY`, input, `N_KEYS`: raw button levels, 1 = pressed. Asynchronous.
- `O_KEY`, output, `N_KEYS`: debounced key level.
- `O_PRESS`, output, `N_KEYS`: one-`I_CLK` pulse per key on a debounced 0→1 change.
- `O_RELEASE`, output, `N_KEYS`: one-`I_CLK` pulse per key on a debounced 1→0 change.

## Operation
- **Synchronizers.** `I_TICK` and each `I_KEY` bit pass through two flip-flops: `*_s1` then `*_s2`.
- **Sample strobe.**
  - `tick_d` is a register holding the previous `tick_s2`.
  - `strobe = tick_s2 & ~tick_d`, one `I_CLK` wide, once per `I_TICK` period.
- **Per-key counter.** Each key has a counter `cnt`, width `$clog2(STABLE+1)`. On each strobe:
  - If `key_s2[i] == O_KEY[i]`: `cnt` ← 0.
  - Else if `cnt == STABLE-1`: `O_KEY[i]` ← `key_s2[i]`, `cnt` ← 0, and the matching pulse register is set.
  - Else: `cnt` ← `cnt+1`.
  - Without a strobe, `cnt` and `O_KEY` hold their values.
- **Pulses.**
  - `O_PRESS[i]` and `O_RELEASE[i]` are registered.
  - Each is 1 only in the cycle after the updating edge, i.e. the first cycle in which `O_KEY[i]` shows its new value.
  - Both are 0 in every other cycle, so they are never asserted together.
- **Glitch rejection.** A differing sample train shorter than `STABLE` strobes, interrupted by one agreeing sample, is discarded. The counter restarts from 0.
- **Key independence.** Keys are fully independent. Any subset may change on the same strobe, and the resulting pulses appear in the same cycle.
- **`STABLE` = 1.** The state flips on the first differing sample.
- **Reset.**
  - All synchronizer flops, `tick_d`, every `cnt`, `O_KEY`, `O_PRESS` and `O_RELEASE` clear to 0.
  - `rst` asserted mid-count abandons the count. No pulse is emitted on the reset cycle or the cycle after.
- **Strobe after reset.** If `I_TICK` is high when `rst` deasserts, `tick_d` = 0 guarantees one strobe 2 cycles after deassertion. This is intended, not a fault.

## Timing
- **Strobe latency.** An `I_TICK` rising edge is seen by `I_CLK` edge k (into `tick_s1`). `tick_s2` is high after edge k+1, so the strobe is active during the cycle after edge k+1. The sample is taken at edge k+2.
- **Key path.** Keys use the same 2-flop path, so a key change is sampled no earlier than 2 cycles after it reaches `tick_s1`'s equivalent stage.
- **Press latency.** From a clean key edge: `STABLE` `I_TICK` periods, plus up to one period of phase, plus 2 cycles of sync. `O_KEY` and the pulse update on the same edge as the `STABLE`-th sample.
- **Throughput.** At most one state change per key per `I_TICK` period. No back-pressure, no handshake.

## Test plan
- **Reset.** Hold `rst`=1 for 5 cycles with `I_KEY`=5'b11111 and `I_TICK` toggling → all outputs 0 throughout. After release, `O_KEY`=5'b11111 on the 4th strobe, `O_PRESS`=5'b11111 for exactly 1 cycle.
- **Clean press/release.** Drive `I_TICK` with period 20 (10 high / 10 low), `STABLE`=4. Set `I_KEY[4]`=1 and hold → `O_KEY[4]` rises on the 4th following strobe with a single `O_PRESS[4]` pulse. Clear the key → 4 strobes later `O_KEY[4]`=0 and a single `O_RELEASE[4]` pulse.
- **Bounce rejection.** Toggle `I_KEY[0]` so samples read 1,1,1,0,1,1,1 → no change after the 0 sample. `O_KEY[0]` rises only after 4 consecutive 1 samples, with exactly one `O_PRESS[0]`.
- **Simultaneous keys.** `I_KEY` goes 0→5'b10101 on one cycle → `O_PRESS`=5'b10101 in a single cycle. `O_PRESS[1]` and `O_PRESS[3]` never assert.
- **Reset mid-count.** After 3 differing samples on key 2, pulse `rst` for 1 cycle → `cnt` restarts, with no pulse. The key needs 4 fresh samples before `O_KEY[2]`=1.
- **`STABLE`=1 build.** The first differing strobe flips the state → pulse appears 1 cycle after that strobe edge. Pulse width is always 1 cycle.

Source files
------------

// File: rtl/key_debounce.sv
// key_debounce
// Debounces and edge-detects the raw tank-control push-buttons. The slow square
// wave from the clock divider is treated as data in the I_CLK domain: its
// synchronized rising edge forms a one-cycle sample strobe. Each key needs
// STABLE consecutive differing samples before its debounced level flips. The
// flip is accompanied by a registered one-cycle press or release pulse.
module key_debounce #(
    parameter int N_KEYS = 5,
    parameter int STABLE = 4
) (
    input  logic              I_CLK,
    input  logic              rst,
    input  logic              I_TICK,
    input  logic [N_KEYS-1:0] I_KEY,
    output logic [N_KEYS-1:0] O_KEY,
    output logic [N_KEYS-1:0] O_PRESS,
    output logic [N_KEYS-1:0] O_RELEASE
);

    // Wide enough to hold STABLE; STABLE=1 still gets a 1-bit counter.
    localparam int CW = $clog2(STABLE + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE - 1);

    logic              tick_s1;
    logic              tick_s2;
    logic              tick_d;
    logic [N_KEYS-1:0] key_s1;
    logic [N_KEYS-1:0] key_s2;
    logic [CW-1:0]     cnt [N_KEYS];
    logic              strobe;

    // Two-flop synchronizers for the divided clock and raw keys, plus the
    // delayed tick used for rising-edge detection. tick_d clears on reset, so a
    // tick that is already high at release still yields one strobe.
    always_ff @(posedge I_CLK) begin
        if (rst) begin
            tick_s1 <= 1'b0;
            tick_s2 <= 1'b0;
            tick_d  <= 1'b0;
            key_s1  <= '0;
            key_s2  <= '0;
        end else begin
            tick_s1 <= I_TICK;
            tick_s2 <= tick_s1;
            tick_d  <= tick_s2;
            key_s1  <= I_KEY;
            key_s2  <= key_s1;
        end
    end

    assign strobe = tick_s2 & ~tick_d;

    // Per-key agreement counters. The debounced level and its edge pulse
    // update on the same edge, so a pulse marks the first cycle of a new level.
    always_ff @(posedge I_CLK) begin
        if (rst) begin
            for (int i = 0; i < N_KEYS; i++) begin
                cnt[i] <= '0;
            end
            O_KEY     <= '0;
            O_PRESS   <= '0;
            O_RELEASE <= '0;
        end else begin
            O_PRESS   <= '0;
            O_RELEASE <= '0;
            if (strobe) begin
                for (int i = 0; i < N_KEYS; i++) begin
                    if (key_s2[i] == O_KEY[i]) begin
                        // an agreeing sample discards any partial train
                        cnt[i] <= '0;
                    end else if (cnt[i] == CNT_LAST) begin
                        O_KEY[i]     <= key_s2[i];
                        cnt[i]       <= '0;
                        O_PRESS[i]   <= key_s2[i];
                        O_RELEASE[i] <= ~key_s2[i];
                    end else begin
                        cnt[i] <= cnt[i] + CW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce
// Two instances (STABLE=4 and STABLE=1) share one stimulus. A sample-level
// reference computes the edge on which each tick rise is sampled. It pushes the
// expected pulse events to a scoreboard queue, and the queue is drained and
// compared every cycle.
module tb_key_debounce;

    localparam int N = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         tick;
    logic [N-1:0] key;
    logic [N-1:0] ok_a, pr_a, rl_a;
    logic [N-1:0] ok_b, pr_b, rl_b;

    key_debounce #(.N_KEYS(N), .STABLE(4)) dut_a (
        .I_CLK(clk), .rst(rst), .I_TICK(tick), .I_KEY(key),
        .O_KEY(ok_a), .O_PRESS(pr_a), .O_RELEASE(rl_a)
    );

    key_debounce #(.N_KEYS(N), .STABLE(1)) dut_b (
        .I_CLK(clk), .rst(rst), .I_TICK(tick), .I_KEY(key),
        .O_KEY(ok_b), .O_PRESS(pr_b), .O_RELEASE(rl_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           at;
        logic [N-1:0] val;
    } samp_t;

    typedef struct {
        int           inst;
        int           at;
        logic [N-1:0] press;
        logic [N-1:0] rel;
    } ev_t;

    samp_t        pend[$];
    ev_t          sb[$];
    int           cyc = 0;
    int           ph = 0;
    int           n_chk = 0;
    int           n_err = 0;
    logic         prev_tick = 1'b0;
    logic [N-1:0] lvl [2];
    int           cnt [2][N];
    int           n_press[N];
    int           n_rel[N];
    int           n_all = 0;
    int           bp[N];
    int           br[N];
    int           ball;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // apply one sample to both reference channels at the current edge
    task automatic apply_sample(input logic [N-1:0] v);
        logic [N-1:0] p;
        logic [N-1:0] r;
        int           stab;
        for (int inst = 0; inst < 2; inst++) begin
            p = '0;
            r = '0;
            stab = (inst == 0) ? 4 : 1;
            for (int i = 0; i < N; i++) begin
                if (v[i] == lvl[inst][i]) begin
                    cnt[inst][i] = 0;
                end else if (cnt[inst][i] + 1 >= stab) begin
                    lvl[inst][i] = v[i];
                    cnt[inst][i] = 0;
                    p[i] = v[i];
                    r[i] = ~v[i];
                end else begin
                    cnt[inst][i] = cnt[inst][i] + 1;
                end
            end
            if ((p | r) != '0) sb.push_back('{inst: inst, at: cyc, press: p, rel: r});
        end
    endtask

    // called right at a rising edge, before the bench changes any input
    task automatic model_update();
        samp_t s;
        if (rst) begin
            prev_tick = 1'b0;
            pend.delete();
            for (int inst = 0; inst < 2; inst++) begin
                lvl[inst] = '0;
                for (int i = 0; i < N; i++) cnt[inst][i] = 0;
            end
        end else begin
            while (pend.size() > 0 && pend[0].at == cyc) begin
                s = pend.pop_front();
                apply_sample(s.val);
            end
            // tick rise seen into the first sync stage now; sampled two edges on
            if (tick && !prev_tick) pend.push_back('{at: cyc + 2, val: key});
            prev_tick = tick;
        end
    endtask

    task automatic monitor();
        logic [N-1:0] ep [2];
        logic [N-1:0] er [2];
        ev_t          e;
        ep[0] = '0; ep[1] = '0; er[0] = '0; er[1] = '0;
        while (sb.size() > 0 && sb[0].at == cyc) begin
            e = sb.pop_front();
            ep[e.inst] = e.press;
            er[e.inst] = e.rel;
        end
        chk("key_a", 32'(ok_a), 32'(lvl[0]));
        chk("press_a", 32'(pr_a), 32'(ep[0]));
        chk("rel_a", 32'(rl_a), 32'(er[0]));
        chk("key_b", 32'(ok_b), 32'(lvl[1]));
        chk("press_b", 32'(pr_b), 32'(ep[1]));
        chk("rel_b", 32'(rl_b), 32'(er[1]));
        for (int i = 0; i < N; i++) begin
            n_press[i] += int'(pr_a[i]);
            n_rel[i]   += int'(rl_a[i]);
        end
        if (pr_a == 5'b10101) n_all++;
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_update();
        #1;
        monitor();
    endtask

    // free-running divided clock: 10 low, 10 high
    task automatic run(input int n);
        repeat (n) begin
            tick = (ph >= 10);
            step();
            ph = (ph + 1) % 20;
        end
    endtask

    task automatic hold(input logic [N-1:0] v, input int k);
        key = v;
        run(20 * k);
    endtask

    task automatic snap();
        for (int i = 0; i < N; i++) begin
            bp[i] = n_press[i];
            br[i] = n_rel[i];
        end
        ball = n_all;
    endtask

    initial begin
        lvl[0] = '0;
        lvl[1] = '0;
        for (int i = 0; i < N; i++) begin
            n_press[i] = 0;
            n_rel[i]   = 0;
            cnt[0][i]  = 0;
            cnt[1][i]  = 0;
        end

        // reset held with keys pressed and the tick toggling
        rst = 1'b1;
        key = 5'b11111;
        tick = 1'b1; step();
        tick = 1'b0; step();
        tick = 1'b1; step();
        tick = 1'b0; step();
        tick = 1'b0; step();
        rst = 1'b0;
        ph = 0;
        snap();
        hold(5'b11111, 3);
        chk("rst_3smp_key", 32'(ok_a), 32'h0);
        hold(5'b11111, 1);
        chk("rst_4smp_key", 32'(ok_a), 32'h1f);
        for (int i = 0; i < N; i++) chk("rst_press_cnt", 32'(n_press[i] - bp[i]), 32'd1);
        snap();
        hold(5'b00000, 4);
        chk("all_rel_key", 32'(ok_a), 32'h0);
        for (int i = 0; i < N; i++) chk("all_rel_cnt", 32'(n_rel[i] - br[i]), 32'd1);

        // clean press and release on key 4
        snap();
        hold(5'b10000, 3);
        chk("k4_3smp", 32'(ok_a), 32'h0);
        hold(5'b10000, 3);
        chk("k4_key", 32'(ok_a), 32'h10);
        chk("k4_press_cnt", 32'(n_press[4] - bp[4]), 32'd1);
        chk("k0_press_cnt", 32'(n_press[0] - bp[0]), 32'd0);
        snap();
        hold(5'b00000, 4);
        chk("k4_rel_key", 32'(ok_a), 32'h0);
        chk("k4_rel_cnt", 32'(n_rel[4] - br[4]), 32'd1);

        // bounce: samples 1,1,1,0,1,1,1 then a fourth 1
        snap();
        hold(5'b00001, 3);
        hold(5'b00000, 1);
        hold(5'b00001, 3);
        chk("bounce_key", 32'(ok_a), 32'h0);
        hold(5'b00001, 1);
        chk("bounce_key_up", 32'(ok_a), 32'h1);
        chk("bounce_press_cnt", 32'(n_press[0] - bp[0]), 32'd1);
        hold(5'b00000, 4);

        // simultaneous keys
        snap();
        hold(5'b10101, 4);
        chk("simul_key", 32'(ok_a), 32'h15);
        chk("simul_one_cycle", 32'(n_all - ball), 32'd1);
        chk("simul_k1_quiet", 32'(n_press[1] - bp[1]), 32'd0);
        chk("simul_k3_quiet", 32'(n_press[3] - bp[3]), 32'd0);
        hold(5'b00000, 4);

        // reset mid-count on key 2
        snap();
        hold(5'b00100, 3);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        hold(5'b00100, 3);
        chk("midrst_key", 32'(ok_a), 32'h0);
        hold(5'b00100, 1);
        chk("midrst_key_up", 32'(ok_a), 32'h4);
        chk("midrst_press_cnt", 32'(n_press[2] - bp[2]), 32'd1);
        hold(5'b00000, 4);

        // random key trains
        repeat (30) hold(5'($urandom_range(0, 31)), $urandom_range(1, 5));

        // tick already high as reset releases: one strobe follows
        rst = 1'b1;
        tick = 1'b1;
        key = 5'b11111;
        step(); step(); step();
        rst = 1'b0;
        step(); step(); step(); step(); step();
        chk("tickhi_b_key", 32'(ok_b), 32'h1f);
        chk("tickhi_a_key", 32'(ok_a), 32'h0);
        ph = 15;
        hold(5'b00000, 4);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
